// File: rtl/color_detect.sv
// Steps a TCS3200-style sensor through red/green/blue filters and counts pulses
// inside each calibrated window. Optional free-running mode: COLOR_AUTO_RESTART_EN.
module color_detect #(
    parameter int unsigned SETTLE_CYCLES = 16,
    localparam int unsigned TIME_W       = 64,
    localparam int unsigned SETTLE_W     = 16,
    localparam int unsigned PULSE_W      = 9,
    localparam int unsigned RES_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frequncy,
    input  logic [TIME_W-1:0] R_time,
    input  logic [TIME_W-1:0] G_time,
    input  logic [TIME_W-1:0] B_time,
    input  logic              cal_ready,
    input  logic              start,
    output logic [1:0]        filter_select,
    output logic [RES_W-1:0]  red,
    output logic [RES_W-1:0]  green,
    output logic [RES_W-1:0]  blue,
    output logic              valid,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET_R = 3'd1;
    localparam logic [2:0] S_WIN_R = 3'd2;
    localparam logic [2:0] S_SET_G = 3'd3;
    localparam logic [2:0] S_WIN_G = 3'd4;
    localparam logic [2:0] S_SET_B = 3'd5;
    localparam logic [2:0] S_WIN_B = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [1:0] FS_RED   = 2'b00;
    localparam logic [1:0] FS_GREEN = 2'b11;
    localparam logic [1:0] FS_BLUE  = 2'b10;
    localparam logic [1:0] FS_CLEAR = 2'b01;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [PULSE_W-1:0]  PULSE_SAT   = PULSE_W'(255);

    logic [2:0]          state, state_nx;
    logic                freq_s1, freq_s2, freq_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_nx;
    logic [TIME_W-1:0]   win_cnt, win_cnt_nx;
    logic [TIME_W-1:0]   win_len, win_len_nx;
    logic [PULSE_W-1:0]  pulse_cnt, pulse_nx;
    logic [RES_W-1:0]    stage_r, stage_r_nx;
    logic [RES_W-1:0]    stage_g, stage_g_nx;
    logic [RES_W-1:0]    red_nx, green_nx, blue_nx;
    logic [1:0]          fs_nx;
    logic                valid_nx, busy_nx;

    logic                edge_c;
    logic                settle_last_c;
    logic                win_last_c;
    logic [PULSE_W-1:0]  pulse_acc_c;
    logic [RES_W-1:0]    result_c;

    // Rising edge of the synchronised sensor wave
    assign edge_c        = freq_s2 & ~freq_d;
    assign settle_last_c = (settle_cnt == SETTLE_LAST);
    // A zero-length window still spends one cycle in WIN_x
    assign win_last_c    = (win_len == '0) || ((win_cnt + TIME_W'(1)) == win_len);
    assign pulse_acc_c   = (edge_c && (pulse_cnt < PULSE_SAT)) ? pulse_cnt + PULSE_W'(1)
                                                               : pulse_cnt;
    // Result includes an edge seen in the final window cycle
    assign result_c      = (win_len == '0)           ? RES_W'(0) :
                           (pulse_acc_c > PULSE_SAT) ? RES_W'(255) :
                                                       pulse_acc_c[RES_W-1:0];

    // Sensor input synchroniser and edge-detect register
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_s1 <= 1'b0;
            freq_s2 <= 1'b0;
            freq_d  <= 1'b0;
        end else begin
            freq_s1 <= frequncy;
            freq_s2 <= freq_s1;
            freq_d  <= freq_s2;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_nx   = state;
        settle_nx  = '0;
        win_cnt_nx = '0;
        win_len_nx = win_len;
        pulse_nx   = '0;
        stage_r_nx = stage_r;
        stage_g_nx = stage_g;
        red_nx     = red;
        green_nx   = green;
        blue_nx    = blue;

        case (state)
            S_IDLE: begin
                if (start && cal_ready) begin
                    state_nx = S_SET_R;
                end
            end
            S_SET_R: begin
                if (settle_last_c) begin
                    state_nx   = S_WIN_R;
                    win_len_nx = R_time;
                end else begin
                    settle_nx = settle_cnt + SETTLE_W'(1);
                end
            end
            S_SET_G: begin
                if (settle_last_c) begin
                    state_nx   = S_WIN_G;
                    win_len_nx = G_time;
                end else begin
                    settle_nx = settle_cnt + SETTLE_W'(1);
                end
            end
            S_SET_B: begin
                if (settle_last_c) begin
                    state_nx   = S_WIN_B;
                    win_len_nx = B_time;
                end else begin
                    settle_nx = settle_cnt + SETTLE_W'(1);
                end
            end
            S_WIN_R: begin
                win_cnt_nx = win_cnt + TIME_W'(1);
                pulse_nx   = pulse_acc_c;
                if (win_last_c) begin
                    state_nx   = S_SET_G;
                    stage_r_nx = result_c;
                end
            end
            S_WIN_G: begin
                win_cnt_nx = win_cnt + TIME_W'(1);
                pulse_nx   = pulse_acc_c;
                if (win_last_c) begin
                    state_nx   = S_SET_B;
                    stage_g_nx = result_c;
                end
            end
            S_WIN_B: begin
                win_cnt_nx = win_cnt + TIME_W'(1);
                pulse_nx   = pulse_acc_c;
                // Publish all three together as DONE is entered
                if (win_last_c) begin
                    state_nx = S_DONE;
                    red_nx   = stage_r;
                    green_nx = stage_g;
                    blue_nx  = result_c;
                end
            end
            S_DONE: begin
`ifdef COLOR_AUTO_RESTART_EN
                state_nx = cal_ready ? S_SET_R : S_IDLE;
`else
                state_nx = S_IDLE;
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        case (state_nx)
            S_SET_R, S_WIN_R: fs_nx = FS_RED;
            S_SET_G, S_WIN_G: fs_nx = FS_GREEN;
            S_SET_B, S_WIN_B: fs_nx = FS_BLUE;
            default:          fs_nx = FS_CLEAR;
        endcase
        valid_nx = (state_nx == S_DONE);
        busy_nx  = (state_nx != S_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt    <= '0;
            win_cnt       <= '0;
            win_len       <= '0;
            pulse_cnt     <= '0;
            stage_r       <= '0;
            stage_g       <= '0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            filter_select <= FS_CLEAR;
            valid         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            settle_cnt    <= settle_nx;
            win_cnt       <= win_cnt_nx;
            win_len       <= win_len_nx;
            pulse_cnt     <= pulse_nx;
            stage_r       <= stage_r_nx;
            stage_g       <= stage_g_nx;
            red           <= red_nx;
            green         <= green_nx;
            blue          <= blue_nx;
            filter_select <= fs_nx;
            valid         <= valid_nx;
            busy          <= busy_nx;
        end
    end

endmodule

// File: tb/tb_color_detect.sv
// Self-checking bench for color_detect: directed runs plus randomized windows and
// sensor periods, checked against an edge-counting reference model.
module tb_color_detect;

    localparam int unsigned SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        frequncy;
    logic [63:0] R_time, G_time, B_time;
    logic        cal_ready;
    logic        start;
    logic [1:0]  filter_select;
    logic [7:0]  red, green, blue;
    logic        valid;
    logic        busy;

    int freq_per = 0;
    int ph = 0;
    int total = 0;
    int bad = 0;

    color_detect #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .frequncy      (frequncy),
        .R_time        (R_time),
        .G_time        (G_time),
        .B_time        (B_time),
        .cal_ready     (cal_ready),
        .start         (start),
        .filter_select (filter_select),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .valid         (valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Sensor model: square wave of freq_per clk cycles, one rising edge per period
    initial begin
        frequncy = 1'b0;
        forever begin
            @(negedge clk);
            if (freq_per < 2) begin
                frequncy = 1'b0;
                ph = 0;
            end else begin
                ph = (ph + 1 >= freq_per) ? 0 : ph + 1;
                frequncy = (ph < freq_per / 2);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input logic [7:0] obs, input int lo, input int hi);
        total++;
        assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Pulses of period p inside a w-cycle window: floor or ceil of w/p, capped at 255
    function automatic void exp_rng(input longint unsigned w, input int p,
                                    output int lo, output int hi);
        longint unsigned q;
        if (w == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            q = w / longint'(p);
            if (q >= 255) begin
                lo = 255;
                hi = 255;
            end else begin
                lo = int'(q);
                hi = (q + (((w % longint'(p)) != 0) ? 1 : 0) > 255) ? 255 :
                     int'(q) + (((w % longint'(p)) != 0) ? 1 : 0);
            end
        end
    endfunction

    function automatic longint unsigned eff(input longint unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic measure(input string name, input longint unsigned r, input longint unsigned g,
                           input longint unsigned b, input int per, input bit poke,
                           input bit drop_cal);
        int n, nval, budget, lo, hi;
        longint unsigned lat;
        bit got;
        logic [7:0] seq;
        logic [1:0] last_fs;
        logic [7:0] r_pub, g_pub, b_pub;
        R_time = r;
        G_time = g;
        B_time = b;
        freq_per = per;
        cal_ready = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b1;
        lat = 3 * SETTLE + eff(r) + eff(g) + eff(b) + 1;
        budget = int'(lat) + 50;
        n = 0;
        got = 1'b0;
        seq = '0;
        last_fs = 2'b01;
        while (!got && n < budget) begin
            @(posedge clk);
            n++;
            #1;
            start = poke && (n == 40);
            if (drop_cal && n == 30) cal_ready = 1'b0;
            if (filter_select !== last_fs) begin
                seq = {seq[5:0], filter_select};
                last_fs = filter_select;
            end
            if (valid === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        check({name, "_valid_seen"}, 64'(got), 64'd1);
        check({name, "_latency"}, 64'(n), lat);
        check({name, "_busy_in_done"}, 64'(busy), 64'd1);
        exp_rng(r, per, lo, hi);
        check_rng({name, "_red"}, red, lo, hi);
        exp_rng(g, per, lo, hi);
        check_rng({name, "_green"}, green, lo, hi);
        exp_rng(b, per, lo, hi);
        check_rng({name, "_blue"}, blue, lo, hi);
        check({name, "_filter_seq"}, 64'(seq), 64'(8'b00_11_10_01));
        r_pub = red;
        g_pub = green;
        b_pub = blue;
        @(posedge clk);
        #1;
        check({name, "_valid_one_cycle"}, 64'(valid), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        nval = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) nval++;
        end
        check({name, "_no_extra_valid"}, 64'(nval), 64'd0);
        check({name, "_hold"}, {40'd0, red, green, blue}, {40'd0, r_pub, g_pub, b_pub});
        cal_ready = 1'b1;
    endtask

    initial begin
        int n;
        longint unsigned rr, gg, bb;
        int pp;
        rst = 1'b1;
        start = 1'b0;
        cal_ready = 1'b0;
        R_time = '0;
        G_time = '0;
        B_time = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_filter", 64'(filter_select), 64'(2'b01));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_rgb", {40'd0, red, green, blue}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // start without calibration is ignored
        R_time = 64'd100;
        G_time = 64'd100;
        B_time = 64'd100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("nocal_busy", 64'(busy), 64'd0);
        check("nocal_filter", 64'(filter_select), 64'(2'b01));
        repeat (5) @(posedge clk);
        #1;
        check("nocal_busy_later", 64'(busy), 64'd0);

        measure("white", 2550, 2550, 2550, 10, 1'b0, 1'b0);
        measure("sat", 2550, 2550, 2550, 5, 1'b0, 1'b0);
        measure("mixed", 2550, 5100, 0, 20, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            rr = longint'($urandom_range(700, 0));
            gg = longint'($urandom_range(700, 0));
            bb = longint'($urandom_range(700, 0));
            if (i == 1) gg = 0;
            pp = int'($urandom_range(9, 2));
            measure($sformatf("rand%0d", i), rr, gg, bb, pp, 1'b0, (i == 2));
        end

        // Reset in the middle of the green window
        R_time = 64'd300;
        G_time = 64'd300;
        B_time = 64'd300;
        freq_per = 4;
        cal_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (filter_select !== 2'b11 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midg_reached_green", 64'(filter_select), 64'(2'b11));
        repeat (SETTLE + 20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midg_filter", 64'(filter_select), 64'(2'b01));
        check("midg_busy", 64'(busy), 64'd0);
        check("midg_valid", 64'(valid), 64'd0);
        check("midg_rgb", {40'd0, red, green, blue}, 64'd0);
        n = 0;
        repeat (800) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1 || busy === 1'b1) n++;
        end
        check("midg_stays_idle", 64'(n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_detect.md
# color_detect

Measurement engine for the TCS3200-style colour sensor that consumes the white-balance calibration result. After calibration, each filter channel has a window length: the number of `clk` cycles the sensor took to emit 255 pulses under a white reference. On `start`, this block steps the sensor through red, green and blue filters. For each channel it counts sensor pulses inside that channel's calibrated window, producing normalised 8-bit R/G/B values (255 = reference white).

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: `clk` cycles waited after each filter change before the window opens (range 1..65535).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frequncy`  in  1  raw sensor square wave, asynchronous to `clk`.
- `R_time`  in  64  calibrated red window length in `clk` cycles.
- `G_time`  in  64  calibrated green window length.
- `B_time`  in  64  calibrated blue window length.
- `cal_ready`  in  1  calibration complete; windows are stable while high.
- `start`  in  1  request one R/G/B measurement; sampled in IDLE only.
- `filter_select`  out  2  sensor filter: 00 red, 11 green, 10 blue, 01 clear (idle).
- `red`, `green`, `blue`  out  8 each  normalised channel results.
- `valid`  out  1  one-cycle pulse when all three results update.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input conditioning: `frequncy` passes through a 2-flop synchroniser plus one edge-detect register. A pulse is one rising edge of the synchronised signal.
- States: IDLE, SET_R, WIN_R, SET_G, WIN_G, SET_B, WIN_B, DONE.
- IDLE:
  - `filter_select` = 01.
  - `start` && `cal_ready` -> SET_R.
  - `start` without `cal_ready` is ignored.
- SET_x:
  - Drive the channel filter code.
  - Count `SETTLE_CYCLES` cycles, then -> WIN_x.
  - On entry to WIN_x, clear the pulse counter and window counter, and latch the window length from x_time.
- WIN_x:
  - The 64-bit window counter increments each cycle.
  - The 9-bit pulse counter increments on each detected edge and saturates at 255.
  - When the window counter equals the latched length, the channel result is staged and the FSM advances (WIN_R -> SET_G, WIN_G -> SET_B, WIN_B -> DONE).
  - An edge detected in the final window cycle is counted.
- Zero-length window (x_time = 0): the result is 0 and the FSM advances after one cycle in WIN_x.
- DONE:
  - `red`/`green`/`blue` are loaded together from the staged values.
  - `valid` = 1 for that single cycle, then -> IDLE.
- Outputs hold their last values between measurements.
- `cal_ready` dropping mid-measurement does not abort; the window lengths already latched are used.

## Timing
- Reset values:
  - `filter_select` = 01; `red`/`green`/`blue` = 0; `valid` = 0; `busy` = 0.
  - FSM in IDLE; synchroniser flops cleared.
- Edge-detect latency: 3 `clk` cycles from the `frequncy` rising edge to the count increment.
- Start latency: `start` sampled at edge N -> `filter_select` = 00 and `busy` = 1 after edge N.
- Total measurement: 3×`SETTLE_CYCLES` + R_time + G_time + B_time + 1 cycles from `start` to `valid`, with each window contributing max(x_time, 1).
- `start` while busy is ignored; there is no queueing.
- Reset asserted mid-measurement: next cycle the FSM is in IDLE with reset output values. Staged partial results are discarded and the previous published results are cleared to 0.
- Window counters compare on the full 64 bits; there is no wrap within any realistic window.

## Configuration
- `COLOR_AUTO_RESTART_EN`:
  - Defined: DONE returns to SET_R instead of IDLE whenever `cal_ready` is high, giving free-running measurement. `busy` stays high and `valid` pulses once per completed triple. `start` is still required for the first run.
  - Undefined: each measurement requires its own `start`.

## Test plan
- Reset mid-WIN_G (`rst` one cycle) -> next cycle: `filter_select`=01, `busy`=0, `red`=`green`=`blue`=0, no `valid`.
- `R_time`=`G_time`=`B_time`=2550, `frequncy` period 10 clk, `start` -> one `valid` pulse; `red`=`green`=`blue` = 255 ±1; `filter_select` sequence 00, 11, 10, 01.
- Same windows, `frequncy` period 5 (510 edges per window) -> all channels saturate at exactly 255.
- `R_time`=2550, `G_time`=5100, `B_time`=0, period 20 -> `red` = 127 or 128; `green` = 255 ±1; `blue` = 0; `valid` at 3×16+2550+5100+1+1 cycles after `start`.
- `start` with `cal_ready`=0 -> `busy` stays 0. `start` pulsed again while busy -> exactly one `valid`.
- With `COLOR_AUTO_RESTART_EN` defined, a single `start` -> `valid` repeats every measurement period until `cal_ready` drops, then the FSM returns to IDLE.
